// File: rtl/id_operand_unit_if.sv
// Bus bundle between the ID operand unit and its surroundings: pipeline control,
// IF/ID hand-off, regfile read data, forwarding sources and resolved outputs.
`ifndef STALL_BUS_DEFINED
`define STALL_BUS_DEFINED
`define StallBus 5:0
`endif

interface id_operand_unit_if #(
  parameter int NUM_FWD = 3,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
);
  logic [`StallBus]          stall;
  logic                      flush;
  logic                      if_ce;
  logic [DATA_W-1:0]         if_pc;
  logic [31:0]               inst;
  logic                      use_rs;
  logic                      use_rt;
  logic [DATA_W-1:0]         rf_rdata1;
  logic [DATA_W-1:0]         rf_rdata2;
  logic [NUM_FWD-1:0]        fwd_we;
  logic [NUM_FWD-1:0]        fwd_is_load;
  logic [NUM_FWD*5-1:0]      fwd_waddr;
  logic [NUM_FWD*DATA_W-1:0] fwd_wdata;
  logic                      id_ce;
  logic [DATA_W-1:0]         id_pc;
  logic [DATA_W-1:0]         rdata1;
  logic [DATA_W-1:0]         rdata2;
  logic                      stallreq;
  logic [CNT_W-1:0]          lu_stall_cnt;

  modport master (
    output stall, flush, if_ce, if_pc, inst, use_rs, use_rt, rf_rdata1, rf_rdata2,
           fwd_we, fwd_is_load, fwd_waddr, fwd_wdata,
    input  id_ce, id_pc, rdata1, rdata2, stallreq, lu_stall_cnt
  );

  modport slave (
    input  stall, flush, if_ce, if_pc, inst, use_rs, use_rt, rf_rdata1, rf_rdata2,
           fwd_we, fwd_is_load, fwd_waddr, fwd_wdata,
    output id_ce, id_pc, rdata1, rdata2, stallreq, lu_stall_cnt
  );
endinterface

// File: rtl/id_operand_unit.sv
// ID-stage operand unit: IF/ID pipeline register, operand forwarding with
// load-use hazard detection, operand hold during stalls and a stall counter.
module id_operand_unit #(
  parameter int NUM_FWD      = 3,
  parameter int DATA_W       = 32,
  parameter int LOAD_RDY_IDX = 2,
  parameter int CNT_W        = 16
) (
  input logic             clk,
  input logic             rst,
  id_operand_unit_if.slave bus
);

  localparam logic NO_STOP = 1'b0;

  typedef enum logic [1:0] {RUN, LU_STALL, HOLD} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              load_pending;
  } operand_t;

  state_t            state;
  logic              id_ce_q;
  logic [DATA_W-1:0] id_pc_q;
  logic [DATA_W-1:0] cap1;
  logic [DATA_W-1:0] cap2;
  logic [CNT_W-1:0]  cnt;
  operand_t          op1;
  operand_t          op2;
  logic              hazard;

  // Scan oldest to youngest so the youngest matching source is the one that sticks.
  function automatic operand_t resolve(input logic [4:0] addr, input logic [DATA_W-1:0] rf);
    operand_t r;
    r.data         = rf;
    r.load_pending = 1'b0;
    for (int j = NUM_FWD - 1; j >= 0; j--) begin
      if (bus.fwd_we[j] && bus.fwd_waddr[j*5 +: 5] == addr) begin
        r.data         = bus.fwd_wdata[j*DATA_W +: DATA_W];
        r.load_pending = bus.fwd_is_load[j] && (j < LOAD_RDY_IDX);
      end
    end
    if (addr == 5'd0) begin
      r.data         = '0;
      r.load_pending = 1'b0;
    end
    return r;
  endfunction

  // NOTE: every always_comb output gets its value on every path, so no latch is inferred.
  always_comb begin
    op1    = resolve(bus.inst[25:21], bus.rf_rdata1);
    op2    = resolve(bus.inst[20:16], bus.rf_rdata2);
    hazard = id_ce_q && (state != HOLD) &&
             ((bus.use_rs && op1.load_pending) || (bus.use_rt && op2.load_pending));
  end

  assign bus.stallreq     = hazard;
  assign bus.rdata1       = (state == HOLD) ? cap1 : op1.data;
  assign bus.rdata2       = (state == HOLD) ? cap2 : op2.data;
  assign bus.id_ce        = id_ce_q;
  assign bus.id_pc        = id_pc_q;
  assign bus.lu_stall_cnt = cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ce_q <= 1'b0;
      id_pc_q <= '0;
    end else if (bus.flush) begin
      id_ce_q <= 1'b0;
      id_pc_q <= '0;
    end else if (bus.stall[1] == NO_STOP) begin
      id_ce_q <= bus.if_ce;
      id_pc_q <= bus.if_pc;
    end else if (bus.stall[2] == NO_STOP) begin
      id_ce_q <= 1'b0;
      id_pc_q <= '0;
    end
  end

  // Operands are snapshotted on the edge that enters HOLD, so sources may retire meanwhile.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cap1  <= '0;
      cap2  <= '0;
    end else if (bus.flush) begin
      state <= RUN;
    end else begin
      unique case (state)
        RUN, LU_STALL: begin
          if (hazard) begin
            state <= LU_STALL;
          end else if (bus.stall[1] != NO_STOP) begin
            state <= HOLD;
            cap1  <= op1.data;
            cap2  <= op2.data;
          end else begin
            state <= RUN;
          end
        end
        HOLD: begin
          if (bus.stall[1] == NO_STOP) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // A flushed instruction's stall cycle is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!bus.flush && hazard && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_operand_unit.sv
// Directed bench for id_operand_unit: a behavioural model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_id_operand_unit;

  localparam int NF = 3;
  localparam int DW = 32;
  localparam int LR = 2;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  id_operand_unit_if #(.NUM_FWD(NF), .DATA_W(DW), .CNT_W(CW)) bus ();

  id_operand_unit #(.NUM_FWD(NF), .DATA_W(DW), .LOAD_RDY_IDX(LR), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_ce   = 0;
  logic [31:0] m_pc   = '0;
  bit          m_hold = 0;
  logic [31:0] m_cap1 = '0;
  logic [31:0] m_cap2 = '0;
  int          m_cnt  = 0;

  function automatic logic [31:0] m_operand(input logic [4:0] a, input logic [31:0] rf);
    if (a == 0) return 32'h0;
    for (int j = 0; j < NF; j++)
      if (bus.fwd_we[j] && bus.fwd_waddr[j*5 +: 5] == a) return bus.fwd_wdata[j*32 +: 32];
    return rf;
  endfunction

  function automatic bit m_load_wait(input logic [4:0] a);
    if (a == 0) return 1'b0;
    for (int j = 0; j < NF; j++)
      if (bus.fwd_we[j] && bus.fwd_waddr[j*5 +: 5] == a) return bus.fwd_is_load[j] && (j < LR);
    return 1'b0;
  endfunction

  function automatic bit m_hazard();
    return m_ce && !m_hold &&
           ((bus.use_rs && m_load_wait(bus.inst[25:21])) ||
            (bus.use_rt && m_load_wait(bus.inst[20:16])));
  endfunction

  always @(posedge clk) begin
    bit hz;
    hz = m_hazard();
    if (rst) begin
      m_ce <= 0; m_pc <= '0; m_hold <= 0; m_cap1 <= '0; m_cap2 <= '0; m_cnt <= 0;
    end else begin
      if (!bus.flush && hz && m_cnt < (1 << CW) - 1) m_cnt <= m_cnt + 1;
      if (bus.flush)          begin m_ce <= 0;         m_pc <= '0;        end
      else if (!bus.stall[1]) begin m_ce <= bus.if_ce; m_pc <= bus.if_pc; end
      else if (!bus.stall[2]) begin m_ce <= 0;         m_pc <= '0;        end
      if (bus.flush) m_hold <= 0;
      else if (m_hold) m_hold <= bus.stall[1];
      else if (!hz && bus.stall[1]) begin
        m_hold <= 1;
        m_cap1 <= m_operand(bus.inst[25:21], bus.rf_rdata1);
        m_cap2 <= m_operand(bus.inst[20:16], bus.rf_rdata2);
      end
    end
  end

  always @(negedge clk) begin
    check("id_ce",    64'(bus.id_ce),        64'(m_ce));
    check("id_pc",    64'(bus.id_pc),        64'(m_pc));
    check("stallreq", 64'(bus.stallreq),     64'(m_hazard()));
    check("rdata1",   64'(bus.rdata1),
          64'(m_hold ? m_cap1 : m_operand(bus.inst[25:21], bus.rf_rdata1)));
    check("rdata2",   64'(bus.rdata2),
          64'(m_hold ? m_cap2 : m_operand(bus.inst[20:16], bus.rf_rdata2)));
    check("lu_cnt",   64'(bus.lu_stall_cnt), 64'(m_cnt));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_src();
    bus.fwd_we      = '0;
    bus.fwd_is_load = '0;
    bus.fwd_waddr   = '0;
    bus.fwd_wdata   = '0;
  endtask

  task automatic set_src(input int j, input bit ld, input logic [4:0] a, input logic [31:0] d);
    bus.fwd_we[j]            = 1'b1;
    bus.fwd_is_load[j]       = ld;
    bus.fwd_waddr[j*5 +: 5]  = a;
    bus.fwd_wdata[j*32 +: 32] = d;
  endtask

  function automatic logic [31:0] mk_inst(input logic [4:0] rs, input logic [4:0] rt);
    return {6'h0, rs, rt, 16'h0};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    bus.stall = '0; bus.flush = 0; bus.if_ce = 0; bus.if_pc = '0; bus.inst = '0;
    bus.use_rs = 0; bus.use_rt = 0; bus.rf_rdata1 = '0; bus.rf_rdata2 = '0;
    clear_src();
    repeat (2) step();
    rst = 1'b0;
    #1;
    check("rst_id_ce", 64'(bus.id_ce), 64'h0);
    check("rst_id_pc", 64'(bus.id_pc), 64'h0);
    check("rst_cnt",   64'(bus.lu_stall_cnt), 64'h0);
    check("rst_stallreq", 64'(bus.stallreq), 64'h0);

    // Youngest forward wins over older, then older over regfile.
    bus.if_ce = 1; bus.if_pc = 32'h100;
    step();
    bus.inst = mk_inst(5, 0); bus.use_rs = 1; bus.rf_rdata1 = 32'hDEAD;
    set_src(0, 0, 5, 32'h1234); set_src(1, 0, 5, 32'h9999);
    #1;
    check("fwd_ex_wins", 64'(bus.rdata1), 64'h1234);
    check("id_pc_load",  64'(bus.id_pc),  64'h100);
    bus.fwd_we[0] = 0;
    #1 check("fwd_mem", 64'(bus.rdata1), 64'h9999);
    clear_src();
    #1 check("fwd_rf", 64'(bus.rdata1), 64'hDEAD);
    step();

    // Load-use hazard at EX, cleared once the load reaches WB.
    bus.inst = mk_inst(0, 8); bus.use_rs = 0; bus.use_rt = 1;
    set_src(0, 1, 8, 32'h5555);
    #1 check("lu_stallreq", 64'(bus.stallreq), 64'h1);
    step();
    clear_src(); set_src(2, 1, 8, 32'h77);
    #1;
    check("lu_cleared", 64'(bus.stallreq), 64'h0);
    check("lu_rdata2",  64'(bus.rdata2),   64'h77);
    check("lu_cnt1",    64'(bus.lu_stall_cnt), 64'h1);
    step();

    // Load at EX but rt unused; writes to r0 never forward.
    clear_src(); set_src(0, 1, 8, 32'h5555); bus.use_rt = 0;
    #1 check("no_use_no_stall", 64'(bus.stallreq), 64'h0);
    clear_src(); set_src(0, 1, 0, 32'hFFFF); set_src(2, 0, 0, 32'hEEEE);
    bus.inst = mk_inst(0, 0); bus.use_rs = 1; bus.use_rt = 1;
    bus.rf_rdata1 = 32'h1234; bus.rf_rdata2 = 32'h4321;
    #1;
    check("r0_rdata1",  64'(bus.rdata1),   64'h0);
    check("r0_rdata2",  64'(bus.rdata2),   64'h0);
    check("r0_nostall", 64'(bus.stallreq), 64'h0);
    step();

    // HOLD: WB forwards r3=0xAA then retires; captured value persists.
    clear_src(); bus.use_rt = 0;
    bus.inst = mk_inst(3, 0); bus.rf_rdata1 = 32'h11;
    set_src(2, 0, 3, 32'hAA);
    bus.stall = 6'b000110;
    #1 check("hold_c1", 64'(bus.rdata1), 64'hAA);
    step();
    clear_src();
    #1 check("hold_c2", 64'(bus.rdata1), 64'hAA);
    step();
    set_src(0, 1, 3, 32'hBB);
    #1;
    check("hold_c3",      64'(bus.rdata1),   64'hAA);
    check("hold_no_haz",  64'(bus.stallreq), 64'h0);
    check("hold_id_ce",   64'(bus.id_ce),    64'h1);
    step();
    clear_src(); bus.stall = '0;
    #1 check("hold_release", 64'(bus.rdata1), 64'hAA);
    step();
    #1 check("run_live", 64'(bus.rdata1), 64'h11);

    // Bubble: ID stopped, EX running.
    bus.if_pc = 32'h200; bus.stall = 6'b000010;
    step();
    #1 check("bubble_id_ce", 64'(bus.id_ce), 64'h0);
    bus.stall = '0;
    step();
    #1 check("bubble_pc", 64'(bus.id_pc), 64'h200);

    // Flush during LU_STALL.
    bus.inst = mk_inst(0, 8); bus.use_rs = 0; bus.use_rt = 1;
    set_src(0, 1, 8, 32'h5555);
    #1 check("flush_haz", 64'(bus.stallreq), 64'h1);
    step();
    bus.flush = 1;
    step();
    bus.flush = 0;
    #1;
    check("flush_id_ce",    64'(bus.id_ce),    64'h0);
    check("flush_stallreq", 64'(bus.stallreq), 64'h0);

    // Saturation of the stall counter.
    repeat ((1 << CW) + 3) step();
    check("cnt_sat", 64'(bus.lu_stall_cnt), 64'hFFFF);

    // Reset overrides flush and stall.
    rst = 1; bus.flush = 1; bus.stall = 6'b111111;
    step();
    rst = 0; bus.flush = 0; bus.stall = '0;
    #1;
    check("rst2_id_ce", 64'(bus.id_ce),        64'h0);
    check("rst2_id_pc", 64'(bus.id_pc),        64'h0);
    check("rst2_cnt",   64'(bus.lu_stall_cnt), 64'h0);
    check("rst2_stall", 64'(bus.stallreq),     64'h0);

    // Reset mid-HOLD discards the captured operand.
    clear_src(); bus.use_rt = 0; bus.use_rs = 1;
    bus.inst = mk_inst(3, 0); bus.rf_rdata1 = 32'h33;
    bus.stall = 6'b000110;
    step();
    bus.rf_rdata1 = 32'h44; rst = 1;
    step();
    rst = 0; bus.stall = '0;
    #1 check("rst_hold_live", 64'(bus.rdata1), 64'h44);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_operand_unit.md
ID_OPERAND_UNIT -- requirements
Module: id_operand_unit

Interface
REQ-001 SHALL have parameter NUM_FWD, default 3: number of forwarding sources; index 0 youngest (EX), highest index oldest (WB).
REQ-002 SHALL have parameter DATA_W, default 32: operand and PC width.
REQ-003 SHALL have parameter LOAD_RDY_IDX, default 2: a load in source j is forwardable only when j >= LOAD_RDY_IDX.
REQ-004 SHALL have parameter CNT_W, default 16: width of the load-use stall counter.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 stall  in  `StallBus  pipeline stall vector; stall[1] stalls this stage, stall[2] stalls EX.
REQ-008 flush  in  1  discard the current ID instruction.
REQ-009 if_ce, if_pc  in  1, DATA_W  IF-to-ID valid and PC.
REQ-010 inst  in  32  instruction word for the registered PC.
REQ-011 use_rs, use_rt  in  1 each  decode reports that the instruction reads rs or rt.
REQ-012 rf_rdata1, rf_rdata2  in  DATA_W each  regfile read data for rs and rt.
REQ-013 fwd_we, fwd_is_load  in  NUM_FWD each  per-source write enable and load flag.
REQ-014 fwd_waddr, fwd_wdata  in  NUM_FWD*5, NUM_FWD*DATA_W  packed per source, source 0 in the LSBs.
REQ-015 id_ce, id_pc  out  1, DATA_W  registered valid and PC.
REQ-016 rdata1, rdata2  out  DATA_W each  resolved operands.
REQ-017 stallreq  out  1  load-use stall request.
REQ-018 lu_stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

Function
REQ-019 Pipeline register SHALL load {if_ce, if_pc} when stall[1]=NoStop, load zero when stall[1]=Stop and stall[2]=NoStop (bubble), and hold otherwise.
REQ-020 rs=inst[25:21] and rt=inst[20:16] SHALL be the operand addresses.
REQ-021 Operand resolution SHALL pick the lowest-index source j with fwd_we[j]=1 and fwd_waddr[j]=address; otherwise it SHALL use the rf_rdata value.
REQ-022 Address 0 SHALL never match a source; operand SHALL be 0.
REQ-023 Hazard SHALL be id_ce and, for rs with use_rs (or rt with use_rt), the selected source j satisfies fwd_is_load[j]=1 and j < LOAD_RDY_IDX.
REQ-024 stallreq SHALL equal the hazard, combinationally, in the same cycle.
REQ-025 FSM states SHALL be RUN, LU_STALL and HOLD; reset and flush SHALL enter RUN.
REQ-026 RUN to LU_STALL on hazard; RUN to HOLD when stall[1]=Stop and there is no hazard; otherwise stay in RUN.
REQ-027 LU_STALL to RUN when the hazard clears and stall[1]=NoStop; LU_STALL to HOLD when the hazard clears and stall[1]=Stop.
REQ-028 On entry to HOLD, both resolved operands SHALL be captured; in HOLD, rdata1 and rdata2 SHALL drive the captured values, ignoring changes on the sources.
REQ-029 HOLD to RUN when stall[1]=NoStop; hazard evaluation SHALL be suppressed in HOLD.
REQ-030 lu_stall_cnt SHALL increment once per cycle with stallreq=1 and SHALL saturate at all-ones.
REQ-031 flush SHALL zero id_ce on the next edge, return the FSM to RUN and leave lu_stall_cnt unchanged; if flush and stall[1] assert together, flush SHALL win.
REQ-032 Output latency SHALL be 0 cycles from the forwarding and regfile inputs to rdata1 and rdata2, except in HOLD.

Reset
REQ-033 On rst=1 at an edge: id_ce=0, id_pc=0, FSM=RUN, captured operands=0, lu_stall_cnt=0.
REQ-034 While id_ce=0, stallreq SHALL be 0.
REQ-035 rst SHALL override flush and stall; reset mid-HOLD or mid-LU_STALL SHALL discard the held state.

Verification
REQ-036 EX source (j=0) writes r5=0x1234, MEM writes r5=0x9999, instruction reads rs=5 -> rdata1=0x1234.
REQ-037 EX source is a load to r8, instruction reads rt=8 with use_rt=1 -> stallreq=1 and state LU_STALL; one cycle later the load is at j=2 -> stallreq=0 and rdata2 = load data; lu_stall_cnt=1.
REQ-038 Same load at j=0 but use_rt=0 -> stallreq=0; a write to r0 from any source -> operand 0.
REQ-039 stall[1]=stall[2]=Stop for 3 cycles while WB (j=2) forwards r3=0xAA and then retires -> rdata1 stays 0xAA throughout HOLD; release returns to RUN.
REQ-040 stall[1]=Stop and stall[2]=NoStop -> id_ce=0 next cycle (bubble); flush during LU_STALL -> id_ce=0 and RUN next cycle.
REQ-041 Force 2^CNT_W+3 hazard cycles -> lu_stall_cnt holds at all-ones; rst -> all outputs return to the REQ-033 values.
